// File: rtl/nios2_oci_dct_packer.sv
// Packs trace frames into words, queues them in a small FIFO and handles
// the end-of-test flush sequence (RUN -> FLUSH -> ENDED).
module nios2_oci_dct_packer #(
  parameter  int FRAME_W         = 2,
  parameter  int FRAMES_PER_WORD = 15,
  parameter  int FIFO_DEPTH      = 4,
  localparam int BUF_W           = FRAME_W * FRAMES_PER_WORD,
  localparam int CNT_W           = 4,
  localparam int LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_valid,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               test_ending,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BUF_W-1:0]   out_data,
  output logic [CNT_W-1:0]   out_count,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               overflow,
  output logic [7:0]         drop_count,
  output logic               test_has_ended
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_ENDED} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [BUF_W-1:0]   r_buf;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_overflow;
  logic [7:0]         r_drop_count;
  logic [BUF_W-1:0]   r_mem_data [FIFO_DEPTH];
  logic [CNT_W-1:0]   r_mem_cnt  [FIFO_DEPTH];

  logic               w_accept;
  logic [BUF_W-1:0]   w_buf_ins;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_full;
  logic               w_pop;
  logic               w_space;
  logic               w_push;
  logic               w_drop;
  logic [BUF_W-1:0]   w_push_data;
  logic [CNT_W-1:0]   w_push_cnt;
  logic [BUF_W-1:0]   w_buf_next;
  logic [CNT_W-1:0]   w_cnt_next;

  assign w_accept  = frame_valid && (r_state == ST_RUN);
  assign w_buf_ins = r_buf | (BUF_W'(frame_data) << (r_cnt * FRAME_W));
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop     = out_valid && out_ready;
  // A pop on the same edge frees the slot a push needs.
  assign w_space   = !w_full || w_pop;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    w_state_next = r_state;
    w_push       = 1'b0;
    w_drop       = 1'b0;
    w_push_data  = w_buf_ins;
    w_push_cnt   = w_cnt_inc;
    w_buf_next   = r_buf;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_accept) begin
          if (w_cnt_inc == CNT_W'(FRAMES_PER_WORD)) begin
            w_buf_next = '0;
            w_cnt_next = '0;
            w_push     = w_space;
            w_drop     = !w_space;
          end else begin
            w_buf_next = w_buf_ins;
            w_cnt_next = w_cnt_inc;
          end
        end
        if (test_ending) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        // The partial word waits for room instead of being dropped.
        w_push_data = r_buf;
        w_push_cnt  = r_cnt;
        if (r_cnt != '0) begin
          if (w_space) begin
            w_push     = 1'b1;
            w_buf_next = '0;
            w_cnt_next = '0;
          end
        end else if (r_level == '0) begin
          w_state_next = ST_ENDED;
        end
      end
      ST_ENDED: ;
      default: w_state_next = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_buf        <= '0;
      r_cnt        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_buf   <= w_buf_next;
      r_cnt   <= w_cnt_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  // NOTE: storage is not reset; the pointers and level define which
  // entries are meaningful, and the output mux hides stale contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_push_data;
      r_mem_cnt[r_wr_ptr]  <= w_push_cnt;
    end
  end

  assign out_valid      = (r_level != '0);
  assign out_data       = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign out_count      = out_valid ? r_mem_cnt[r_rd_ptr] : '0;
  assign fifo_level     = r_level;
  assign overflow       = r_overflow;
  assign drop_count     = r_drop_count;
  assign test_has_ended = (r_state == ST_ENDED);

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Directed bench for nios2_oci_dct_packer: expected words go into a queue
// at stimulus time and a negedge monitor compares every popped word.
module tb_nios2_oci_dct_packer;

  localparam int BUF_W = 30;
  localparam int CNT_W = 4;
  localparam int LVL_W = 3;

  typedef struct packed {
    logic [BUF_W-1:0] data;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             frame_valid;
  logic [1:0]       frame_data;
  logic             test_ending;
  logic             out_valid;
  logic             out_ready;
  logic [BUF_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic [7:0]       drop_count;
  logic             test_has_ended;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  nios2_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .test_ending    (test_ending),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_count      (out_count),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops the oldest expected word.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got 0x%0h/%0d expected none", out_data, out_count);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("word_data", 32'(out_data), 32'(e.data));
        check("word_count", 32'(out_count), 32'(e.cnt));
      end
    end
  end

  function automatic logic [BUF_W-1:0] fill(input logic [1:0] d);
    logic [BUF_W-1:0] r;
    r = '0;
    for (int i = 0; i < 15; i++) r[2*i +: 2] = d;
    return r;
  endfunction

  task automatic expect_word(input logic [BUF_W-1:0] d, input logic [CNT_W-1:0] c);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    q.push_back(e);
  endtask

  task automatic send_frame(input logic [1:0] d);
    frame_valid = 1'b1;
    frame_data  = d;
    @(posedge clk); #1;
    frame_valid = 1'b0;
  endtask

  task automatic send_word(input logic [1:0] d, input bit keep);
    if (keep) expect_word(fill(d), 4'd15);
    for (int i = 0; i < 15; i++) send_frame(d);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    frame_valid = 1'b0;
    frame_data  = '0;
    test_ending = 1'b0;
    out_ready   = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    out_ready = 1'b1;
    while ((out_valid || fifo_level != 0) && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    check("drain_level", 32'(fifo_level), 0);
    check("scoreboard_empty", q.size(), 0);
  endtask

  task automatic wait_ended();
    int i = 0;
    while (!test_has_ended && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    check("test_has_ended", 32'(test_has_ended), 1);
  endtask

  initial begin
    // Reset values while reset is held.
    reset = 1'b1; frame_valid = 1'b0; frame_data = '0; test_ending = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_count", 32'(out_count), 0);
    check("rst_fifo_level", 32'(fifo_level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drop_count", 32'(drop_count), 0);
    check("rst_ended", 32'(test_has_ended), 0);
    reset = 1'b0;

    // One word of frame data k mod 4; out_valid the cycle after frame 15.
    out_ready = 1'b1;
    expect_word(30'h24E4E4E4, 4'd15);
    for (int k = 0; k < 14; k++) send_frame(2'(k % 4));
    check("t1_valid_before", 32'(out_valid), 0);
    send_frame(2'(14 % 4));
    check("t1_valid_latency", 32'(out_valid), 1);
    drain();

    // Overflow: four words stored, fifth dropped, then drained in order.
    do_reset();
    send_word(2'd1, 1'b1);
    send_word(2'd2, 1'b1);
    send_word(2'd3, 1'b1);
    send_word(2'd0, 1'b1);
    send_word(2'd1, 1'b0);
    check("t2_level", 32'(fifo_level), 4);
    check("t2_overflow", 32'(overflow), 1);
    check("t2_drop_count", 32'(drop_count), 1);
    repeat (3) @(posedge clk);
    #1;
    check("t2_stall_data", 32'(out_data), 32'h15555555);
    check("t2_stall_count", 32'(out_count), 15);
    drain();

    // Full FIFO, word completes while a pop happens: nothing dropped.
    do_reset();
    send_word(2'd1, 1'b1);
    send_word(2'd2, 1'b1);
    send_word(2'd3, 1'b1);
    send_word(2'd1, 1'b1);
    expect_word(fill(2'd2), 4'd15);
    for (int i = 0; i < 14; i++) send_frame(2'd2);
    out_ready = 1'b1;
    send_frame(2'd2);
    out_ready = 1'b0;
    check("t3_level", 32'(fifo_level), 4);
    check("t3_overflow", 32'(overflow), 0);
    check("t3_drop_count", 32'(drop_count), 0);
    drain();

    // Partial flush: 5 frames of 2'b11.
    do_reset();
    out_ready = 1'b1;
    expect_word(30'h3FF, 4'd5);
    for (int i = 0; i < 5; i++) send_frame(2'd3);
    test_ending = 1'b1;
    @(posedge clk); #1;
    test_ending = 1'b0;
    wait_ended();
    check("t4_fifo_empty", 32'(fifo_level), 0);
    frame_valid = 1'b1; frame_data = 2'd1; test_ending = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    frame_valid = 1'b0; test_ending = 1'b0;
    check("t4_stays_ended", 32'(test_has_ended), 1);
    check("t4_ended_level", 32'(fifo_level), 0);

    // Frame accepted with test_ending, repeated test_ending in FLUSH.
    do_reset();
    expect_word(30'h95, 4'd4);
    for (int i = 0; i < 3; i++) send_frame(2'd1);
    test_ending = 1'b1;
    send_frame(2'd2);
    repeat (3) @(posedge clk);
    #1;
    test_ending = 1'b0;
    check("t5_level", 32'(fifo_level), 1);
    check("t5_not_ended", 32'(test_has_ended), 0);
    check("t5_head_data", 32'(out_data), 32'h95);
    check("t5_head_count", 32'(out_count), 4);
    out_ready = 1'b1;
    wait_ended();

    // Reset mid-flush with words queued, then a fresh word.
    do_reset();
    send_word(2'd1, 1'b1);
    send_word(2'd2, 1'b1);
    send_word(2'd3, 1'b1);
    for (int i = 0; i < 5; i++) send_frame(2'd3);
    test_ending = 1'b1;
    @(posedge clk); #1;
    test_ending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_level_before", 32'(fifo_level), 4);
    reset = 1'b1;
    q.delete();
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_data", 32'(out_data), 0);
    check("t6_rst_level", 32'(fifo_level), 0);
    check("t6_rst_ended", 32'(test_has_ended), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    check("t6_deassert_valid", 32'(out_valid), 0);
    expect_word(30'h24E4E4E4, 4'd15);
    for (int k = 0; k < 15; k++) send_frame(2'(k % 4));
    drain();

    // Drop counter saturation.
    do_reset();
    for (int w = 0; w < 304; w++) send_word(2'd1, w < 4);
    check("t7_drop_sat", 32'(drop_count), 255);
    check("t7_overflow", 32'(overflow), 1);
    check("t7_level", 32'(fifo_level), 4);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nios2_oci_dct_packer.md
NIOS2_OCI_DCT_PACKER -- requirements
Module: nios2_oci_dct_packer

Interface
REQ-001 Parameter FRAME_W, default 2, sets the bits per trace frame.
REQ-002 Parameter FRAMES_PER_WORD, default 15, sets the frames per packed word (range 1..15).
REQ-003 Parameter FIFO_DEPTH, default 4, sets the number of packed-word entries (power of two, 2..64).
REQ-004 Derived widths SHALL be BUF_W = FRAME_W*FRAMES_PER_WORD (default 30), CNT_W = 4 and LVL_W = clog2(FIFO_DEPTH)+1.
REQ-005 Ports SHALL be as follows; one clock; reset is asynchronous and active-high.
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- frame_valid  in  1  frame_data is valid this cycle.
- frame_data  in  FRAME_W  trace frame.
- test_ending  in  1  request to flush and finish.
- out_valid  out  1  out_data/out_count hold a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  BUF_W  packed word, equivalent to dct_buffer.
- out_count  out  CNT_W  number of valid frames in out_data, equivalent to dct_count.
- fifo_level  out  LVL_W  number of words stored.
- overflow  out  1  sticky flag: a word was dropped.
- drop_count  out  8  count of dropped words, saturating.
- test_has_ended  out  1  flush is complete and the FIFO is empty.

Function
REQ-006 A frame SHALL be accepted when frame_valid=1 and the state is RUN; in any other state the frame is ignored.
REQ-007 Frame k of a word (k = 0..FRAMES_PER_WORD-1) SHALL occupy bits [k*FRAME_W +: FRAME_W]; unused upper bits SHALL be 0.
REQ-008 When the accepted frame brings the fill count to FRAMES_PER_WORD, the word and its count SHALL be written to the FIFO in the same cycle.
REQ-009 On that same cycle the assembly buffer and fill count SHALL clear.
REQ-010 A written word SHALL appear on out_valid on the next cycle when the FIFO was empty, so frame-to-out_valid latency is 1 cycle.
REQ-011 The FIFO SHALL be first-in first-out.
REQ-012 A pop SHALL occur when out_valid and out_ready are both 1.
REQ-013 out_data and out_count SHALL remain stable while out_valid=1 and out_ready=0.
REQ-014 A push and a pop in the same cycle SHALL be permitted when the FIFO is full, leaving the level unchanged and dropping nothing.
REQ-015 In RUN, a word completed while the FIFO is full with no simultaneous pop SHALL be discarded.
REQ-016 On such a discard, overflow SHALL be set to 1 and drop_count incremented, saturating at 255.
REQ-017 The state machine SHALL have three states: RUN, FLUSH and ENDED.
REQ-018 In RUN, test_ending=1 SHALL move the state to FLUSH; a frame accepted in that same cycle is included in the buffer first.
REQ-019 If that frame completes a word, the word is pushed normally under REQ-008.
REQ-020 In FLUSH with a nonzero fill count, the partial word (zero-padded, out_count = fill count) SHALL be pushed as soon as the FIFO is not full; it is never dropped in FLUSH.
REQ-021 In FLUSH with fill count 0 and fifo_level 0, the state SHALL move to ENDED.
REQ-022 In ENDED, test_has_ended SHALL be 1, and the block SHALL remain in ENDED until reset, ignoring test_ending.
REQ-023 test_ending asserted again while in FLUSH SHALL have no effect.
REQ-024 fifo_level SHALL equal the number of stored words at every cycle.

Reset
REQ-025 While reset=1, the state SHALL be RUN.
REQ-026 While reset=1, the fill count, the buffer and the FIFO pointers SHALL be 0.
REQ-027 While reset=1, the outputs SHALL be out_valid=0, out_data=0, out_count=0, fifo_level=0, overflow=0, drop_count=0 and test_has_ended=0.
REQ-028 Reset asserted mid-word or mid-flush SHALL discard all buffered and partial data, with no output handshake on the cycle reset deasserts.

Verification
REQ-029 Defaults, out_ready=1, 15 frames of data k mod 4 -> one word with out_count=15 and frame k at bits [2k+1:2k]; out_valid is 1 the cycle after the 15th frame.
REQ-030 out_ready=0, 75 frames -> fifo_level=4, 5th word dropped, overflow=1, drop_count=1; out_ready=1 then yields 4 words in order.
REQ-031 5 frames of 2'b11 then test_ending -> out_data=0x3FF, out_count=5, then test_has_ended=1 once the FIFO is empty.
REQ-032 Full FIFO, word completion with simultaneous pop -> no drop, fifo_level stays 4.
REQ-033 Reset asserted mid-FLUSH with 3 words queued -> all outputs 0, state RUN; a fresh 15-frame word then packs correctly.
REQ-034 300 dropped words -> drop_count=255, overflow=1.
